// File: rtl/id_registrar.sv
// Player ID registrar: collects a 4-digit BCD ID, scans the ID RAM for duplicates and the
// end marker, then appends the ID. Optional abort input during digit entry: REG_ABORT_EN.
module id_registrar #(
    parameter int          DEPTH    = 8,
    parameter int          RD_WAIT  = 2,
    parameter logic [15:0] END_MARK = 16'hFFFF,
    parameter logic [15:0] GUEST_ID = 16'h1111
) (
    input  logic        clk,
    input  logic        rst,
`ifdef REG_ABORT_EN
    input  logic        abort,
`endif
    input  logic [3:0]  idDigit,
    input  logic        b_id,
    input  logic [15:0] mem_rdata,
    output logic [4:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic        dup,
    output logic        full,
    output logic        rejected,
    output logic [2:0]  newPlayerID
);

    localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);
    localparam int         WC_W     = (RD_WAIT > 1) ? $clog2(RD_WAIT + 1) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);

    typedef enum logic [3:0] {
        S_DIGIT1   = 4'd0,
        S_DIGIT2   = 4'd1,
        S_DIGIT3   = 4'd2,
        S_DIGIT4   = 4'd3,
        S_CHECKRES = 4'd4,
        S_FETCH    = 4'd5,
        S_WAIT     = 4'd6,
        S_CATCH    = 4'd7,
        S_COMPARE  = 4'd8,
        S_WR_END   = 4'd9,
        S_WR_ID    = 4'd10,
        S_REPORT   = 4'd11
    } state_t;

    state_t          state_q;
    logic [15:0]     uid_q;
    logic [15:0]     rid_q;
    logic [4:0]      idx_q;
    logic [WC_W-1:0] wait_q;
    logic [4:0]      mem_addr_q;
    logic [15:0]     mem_wdata_q;
    logic            mem_we_q;
    logic            busy_q;
    logic            done_q;
    logic            ok_q;
    logic            dup_q;
    logic            full_q;
    logic            rejected_q;
    logic [2:0]      npid_q;
    logic            abort_s;

`ifdef REG_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Registrar FSM: digit capture, table scan, two-word append, and result reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_DIGIT1;
            uid_q       <= 16'h0000;
            rid_q       <= 16'h0000;
            idx_q       <= 5'd0;
            wait_q      <= '0;
            mem_addr_q  <= 5'd0;
            mem_wdata_q <= 16'h0000;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            dup_q       <= 1'b0;
            full_q      <= 1'b0;
            rejected_q  <= 1'b0;
            npid_q      <= 3'd0;
        end else begin
            case (state_q)
                S_DIGIT1: begin
                    if (b_id) begin
                        uid_q[15:12] <= idDigit;
                        ok_q         <= 1'b0;
                        dup_q        <= 1'b0;
                        full_q       <= 1'b0;
                        rejected_q   <= 1'b0;
                        npid_q       <= 3'd0;
                        state_q      <= S_DIGIT2;
                    end
                end
                S_DIGIT2: begin
                    if (abort_s) begin
                        uid_q   <= 16'h0000;
                        state_q <= S_DIGIT1;
                    end else if (b_id) begin
                        uid_q[11:8] <= idDigit;
                        state_q     <= S_DIGIT3;
                    end
                end
                S_DIGIT3: begin
                    if (abort_s) begin
                        uid_q   <= 16'h0000;
                        state_q <= S_DIGIT1;
                    end else if (b_id) begin
                        uid_q[7:4] <= idDigit;
                        state_q    <= S_DIGIT4;
                    end
                end
                S_DIGIT4: begin
                    if (abort_s) begin
                        uid_q   <= 16'h0000;
                        state_q <= S_DIGIT1;
                    end else if (b_id) begin
                        uid_q[3:0] <= idDigit;
                        busy_q     <= 1'b1;
                        state_q    <= S_CHECKRES;
                    end
                end
                S_CHECKRES: begin
                    if ((uid_q == END_MARK) || (uid_q == GUEST_ID)) begin
                        rejected_q <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_REPORT;
                    end else begin
                        idx_q   <= 5'd0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    mem_addr_q <= idx_q;
                    wait_q     <= '0;
                    state_q    <= (RD_WAIT == 0) ? S_CATCH : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= S_CATCH;
                    end else begin
                        wait_q <= wait_q + WC_W'(1);
                    end
                end
                S_CATCH: begin
                    rid_q   <= mem_rdata;
                    state_q <= S_COMPARE;
                end
                S_COMPARE: begin
                    if (rid_q == uid_q) begin
                        dup_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_REPORT;
                    end else if ((rid_q == END_MARK) && (idx_q == LAST_IDX)) begin
                        // Marker in the last slot leaves no room for both the ID and a new marker.
                        full_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_REPORT;
                    end else if (rid_q == END_MARK) begin
                        mem_addr_q  <= idx_q + 5'd1;
                        mem_wdata_q <= END_MARK;
                        mem_we_q    <= 1'b1;
                        state_q     <= S_WR_END;
                    end else if (idx_q == LAST_IDX) begin
                        full_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_REPORT;
                    end else begin
                        idx_q   <= idx_q + 5'd1;
                        state_q <= S_FETCH;
                    end
                end
                S_WR_END: begin
                    // New marker is already in place; now overwrite the old marker slot with the ID.
                    mem_addr_q  <= idx_q;
                    mem_wdata_q <= uid_q;
                    mem_we_q    <= 1'b1;
                    state_q     <= S_WR_ID;
                end
                S_WR_ID: begin
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= 16'h0000;
                    ok_q        <= 1'b1;
                    npid_q      <= idx_q[2:0];
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= S_REPORT;
                end
                S_REPORT: begin
                    done_q  <= 1'b0;
                    state_q <= S_DIGIT1;
                end
                default: begin
                    state_q     <= S_DIGIT1;
                    uid_q       <= 16'h0000;
                    idx_q       <= 5'd0;
                    wait_q      <= '0;
                    mem_addr_q  <= 5'd0;
                    mem_wdata_q <= 16'h0000;
                    mem_we_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    ok_q        <= 1'b0;
                    dup_q       <= 1'b0;
                    full_q      <= 1'b0;
                    rejected_q  <= 1'b0;
                    npid_q      <= 3'd0;
                end
            endcase
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ok          = ok_q;
    assign dup         = dup_q;
    assign full        = full_q;
    assign rejected    = rejected_q;
    assign newPlayerID = npid_q;

endmodule

// File: tb/tb_id_registrar.sv
// Directed bench for id_registrar with a registered-read RAM model and hand-computed results.
module tb_id_registrar;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  idDigit;
    logic        b_id;
    logic [15:0] rdata;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        busy, done, ok, dup, full, rejected;
    logic [2:0]  newPlayerID;
`ifdef REG_ABORT_EN
    logic        abort;
`endif

    logic [15:0] mem      [32];
    logic [15:0] init_tbl [32];
    logic        do_load;
    int          wr_cnt = 0;
    logic [4:0]  last_wr_addr = 5'd0;
    logic [4:0]  prev_wr_addr = 5'd0;
    logic        wdata_bad = 1'b0;

    int checks = 0;
    int errors = 0;
    int lat;
    int wb;
    int n;

    id_registrar dut (
        .clk         (clk),
        .rst         (rst),
`ifdef REG_ABORT_EN
        .abort       (abort),
`endif
        .idDigit     (idDigit),
        .b_id        (b_id),
        .mem_rdata   (rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .busy        (busy),
        .done        (done),
        .ok          (ok),
        .dup         (dup),
        .full        (full),
        .rejected    (rejected),
        .newPlayerID (newPlayerID)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle registered read, write port, and bulk table load.
    always @(posedge clk) begin
        rdata <= mem[mem_addr];
        if (do_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_tbl[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
            prev_wr_addr  <= last_wr_addr;
            last_wr_addr  <= mem_addr;
        end
    end

    // Sticky flag: write data must be zero whenever no write is in progress.
    always @(negedge clk) begin
        if (!mem_we && (mem_wdata !== 16'h0000)) wdata_bad <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 32; i++) init_tbl[i] = v;
    endtask

    task automatic load();
        do_load = 1'b1;
        @(posedge clk); #1;
        do_load = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        idDigit = d;
        b_id    = 1'b1;
        @(posedge clk); #1;
        b_id    = 1'b0;
        @(posedge clk); #1;
    endtask

    // Enters a full ID, returns cycles from CHECKRES (=1) through the done cycle, then steps past REPORT.
    task automatic entry(input logic [15:0] id, input bit noise, output int l);
        press(id[15:12]);
        press(id[11:8]);
        press(id[7:4]);
        idDigit = id[3:0];
        b_id    = 1'b1;
        @(posedge clk); #1;
        b_id    = 1'b0;
        l = 1;
        while (!done && l < 200) begin
            b_id    = noise && ((l % 4) == 2);
            idDigit = 4'h9;
            @(posedge clk); #1;
            l++;
        end
        b_id = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
        check(tag, 32'({ok, dup, full, rejected}), 32'(exp));
    endtask

    initial begin
        rst     = 1'b1;
        b_id    = 1'b0;
        idDigit = 4'h0;
        do_load = 1'b0;
`ifdef REG_ABORT_EN
        abort   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_addr",  32'(mem_addr), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_ctl",   32'({mem_we, busy, done}), 32'h0);
        check_flags("rst_flags", 4'b0000);
        check("rst_npid",  32'(newPlayerID), 32'h0);

        // Test 1: append after two entries
        fill(16'h0000);
        init_tbl[0] = 16'h1111; init_tbl[1] = 16'h2345; init_tbl[2] = 16'hFFFF;
        load();
        wb = wr_cnt;
        entry(16'h3901, 1'b0, lat);
        check("t1_lat",    32'(lat), 32'd19);
        check_flags("t1_flags", 4'b1000);
        check("t1_npid",   32'(newPlayerID), 32'd2);
        check("t1_nwr",    32'(wr_cnt - wb), 32'd2);
        check("t1_wr1adr", 32'(prev_wr_addr), 32'd3);
        check("t1_wr2adr", 32'(last_wr_addr), 32'd2);
        check("t1_mem3",   32'(mem[3]), 32'hFFFF);
        check("t1_mem2",   32'(mem[2]), 32'h3901);
        check("t1_mem0",   32'(mem[0]), 32'h1111);
        check("t1_mem1",   32'(mem[1]), 32'h2345);
        check("t1_idle",   32'({busy, done, mem_we}), 32'h0);

        // Test 2: duplicate at slot 1
        wb = wr_cnt;
        entry(16'h2345, 1'b0, lat);
        check("t2_lat",  32'(lat), 32'd12);
        check_flags("t2_flags", 4'b0100);
        check("t2_npid", 32'(newPlayerID), 32'd0);
        check("t2_nwr",  32'(wr_cnt - wb), 32'd0);

        // Test 3: full with marker in last slot, then no marker at all
        fill(16'h0000);
        for (int i = 0; i < 7; i++) init_tbl[i] = 16'h1000 + 16'(i);
        init_tbl[7] = 16'hFFFF;
        load();
        wb = wr_cnt;
        entry(16'h4444, 1'b0, lat);
        check("t3a_lat", 32'(lat), 32'd42);
        check_flags("t3a_flags", 4'b0010);
        check("t3a_nwr", 32'(wr_cnt - wb), 32'd0);
        init_tbl[7] = 16'h1007;
        load();
        entry(16'h4444, 1'b0, lat);
        check("t3b_lat", 32'(lat), 32'd42);
        check_flags("t3b_flags", 4'b0010);
        check("t3b_nwr", 32'(wr_cnt - wb), 32'd0);

        // Marker at slot 6 still leaves room: ID goes to 6, marker to 7
        init_tbl[6] = 16'hFFFF; init_tbl[7] = 16'h0000;
        load();
        entry(16'h4444, 1'b0, lat);
        check("t3c_lat",  32'(lat), 32'd39);
        check_flags("t3c_flags", 4'b1000);
        check("t3c_npid", 32'(newPlayerID), 32'd6);
        check("t3c_mem7", 32'(mem[7]), 32'hFFFF);
        check("t3c_mem6", 32'(mem[6]), 32'h4444);

        // Test 4: reserved IDs rejected immediately; b_id noise during a scan ignored
        wb = wr_cnt;
        entry(16'h1111, 1'b0, lat);
        check("t4a_lat", 32'(lat), 32'd2);
        check_flags("t4a_flags", 4'b0001);
        entry(16'hFFFF, 1'b0, lat);
        check("t4b_lat", 32'(lat), 32'd2);
        check_flags("t4b_flags", 4'b0001);
        check("t4_nwr",  32'(wr_cnt - wb), 32'd0);
        fill(16'h0000);
        init_tbl[0] = 16'h1111; init_tbl[1] = 16'h2345; init_tbl[2] = 16'hFFFF;
        load();
        entry(16'h4444, 1'b1, lat);
        check("t4c_lat",  32'(lat), 32'd19);
        check_flags("t4c_flags", 4'b1000);
        check("t4c_mem2", 32'(mem[2]), 32'h4444);

        // Test 5: reset lands on the marker write; ID slot stays untouched
        load();
        press(4'h6); press(4'h7); press(4'h8);
        idDigit = 4'h9;
        b_id    = 1'b1;
        @(posedge clk); #1;
        b_id = 1'b0;
        n = 0;
        while (!mem_we && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_wrend_addr", 32'({mem_we, mem_addr}), 32'({1'b1, 5'd3}));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_rst_ctl",   32'({mem_we, busy, done}), 32'h0);
        check("t5_rst_bus",   32'({mem_addr, mem_wdata}), 32'h0);
        check_flags("t5_rst_flags", 4'b0000);
        check("t5_mem3",      32'(mem[3]), 32'hFFFF);
        check("t5_mem2",      32'(mem[2]), 32'hFFFF);
        entry(16'h6789, 1'b0, lat);
        check("t5_lat",    32'(lat), 32'd19);
        check_flags("t5_flags", 4'b1000);
        check("t5_npid",   32'(newPlayerID), 32'd2);
        check("t5_newid",  32'(mem[2]), 32'h6789);

`ifdef REG_ABORT_EN
        // Test 6: abort mid-entry restarts digit capture
        load();
        press(4'h5); press(4'h6);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t6_noreport", 32'({busy, done}), 32'h0);
        entry(16'h7890, 1'b0, lat);
        check_flags("t6_flags", 4'b1000);
        check("t6_mem2", 32'(mem[2]), 32'h7890);
`endif

        check("wdata_zero_when_idle", 32'(wdata_bad), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
